// File: rtl/cam_pkg.sv
// Shared definitions for the camera-to-frame-buffer write path.
package cam_pkg;
  localparam int CAM_H           = 640;
  localparam int CAM_V           = 480;
  localparam int CAM_FRAME_WORDS = CAM_H * CAM_V;
  localparam int CAM_BURST_LEN   = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } cam_state_e;
endpackage

// File: rtl/cam_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count and synchronous flush.
module cam_sync_fifo #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is not reset; stale contents are never observable because rd_data is masked while empty.
  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;
endmodule

// File: rtl/cam_burst_writer.sv
// Buffers camera pixels and issues fixed-length, address-qualified write bursts
// to the frame buffer, restarting the frame address on each vsync rising edge.
module cam_burst_writer
  import cam_pkg::*;
#(
  parameter int BURST_LEN   = CAM_BURST_LEN,
  parameter int FIFO_DEPTH  = 512,
  parameter int ADDR_W      = 22,
  parameter int FRAME_WORDS = CAM_FRAME_WORDS
) (
  input  logic              cmos_pclk,
  input  logic              rst,
  input  logic [15:0]       data_16b,
  input  logic              data_16b_en,
  input  logic              cmos_vsyn,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_ack,
  output logic [15:0]       wr_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic              frame_done,
  output logic              ovf
);
  localparam int BW = $clog2(BURST_LEN);
  localparam int CW = $clog2(FIFO_DEPTH);

  cam_state_e        state_q, state_d;
  logic              vsyn_d1_q;
  logic              sof_pend_q, sof_pend_d;
  logic [BW:0]       beat_q, beat_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              frame_done_q, frame_done_d;
  logic              ovf_q, ovf_d;

  logic [CW:0]       fifo_count;
  logic              fifo_full, fifo_empty;
  logic [15:0]       fifo_rd_data;
  logic              sof, flush, fifo_rd, fifo_wr, last_beat, wrap;
  logic [ADDR_W:0]   addr_sum;

  assign sof       = cmos_vsyn && !vsyn_d1_q;
  // A frame start seen mid-burst is deferred until the burst is back in IDLE.
  assign flush     = (state_q == IDLE) && (sof || sof_pend_q);
  assign fifo_rd   = wr_valid && wr_ready;
  assign fifo_wr   = data_16b_en && !flush;
  assign last_beat = fifo_rd && (beat_q == (BW+1)'(BURST_LEN - 1));
  assign addr_sum  = {1'b0, wr_addr_q} + (ADDR_W+1)'(BURST_LEN);
  assign wrap      = (addr_sum == (ADDR_W+1)'(FRAME_WORDS));

  cam_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk     (cmos_pclk),
    .rst     (rst),
    .flush   (flush),
    .wr_en   (fifo_wr),
    .wr_data (data_16b),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      vsyn_d1_q    <= 1'b0;
      sof_pend_q   <= 1'b0;
      beat_q       <= '0;
      wr_addr_q    <= '0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsyn_d1_q    <= cmos_vsyn;
      sof_pend_q   <= sof_pend_d;
      beat_q       <= beat_d;
      wr_addr_q    <= wr_addr_d;
      frame_done_q <= frame_done_d;
      ovf_q        <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!flush && fifo_count >= (CW+1)'(BURST_LEN)) state_d = REQ;
      REQ:     if (wr_ack) state_d = DATA;
      DATA:    if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sof_pend_d   = sof_pend_q;
    beat_d       = beat_q;
    wr_addr_d    = wr_addr_q;
    frame_done_d = 1'b0;
    ovf_d        = ovf_q || (data_16b_en && !flush && fifo_full && !fifo_rd);
    if (flush) begin
      sof_pend_d = 1'b0;
      beat_d     = '0;
      wr_addr_d  = '0;
    end else if (sof) begin
      sof_pend_d = 1'b1;
    end
    if (fifo_rd) beat_d = beat_q + 1'b1;
    if (last_beat) begin
      beat_d       = '0;
      wr_addr_d    = wrap ? '0 : addr_sum[ADDR_W-1:0];
      frame_done_d = wrap;
    end
  end

  always_comb begin
    wr_req     = (state_q == REQ);
    wr_valid   = (state_q == DATA) && !fifo_empty;
    wr_data    = fifo_rd_data;
    wr_addr    = wr_addr_q;
    frame_done = frame_done_q;
    ovf        = ovf_q;
  end
endmodule

// File: tb/tb_cam_burst_writer.sv
// Directed bench for cam_burst_writer: a per-burst vector table over one short frame,
// plus hand-written threshold, overflow and mid-burst frame-start sequences.
module tb_cam_burst_writer;
  localparam int BURST = 256;
  localparam int DEPTH = 512;
  localparam int AW    = 22;
  localparam int FRAME = 2048;
  localparam int HOLD  = 1_000_000;

  logic          cmos_pclk = 1'b0;
  logic          rst;
  logic [15:0]   data_16b;
  logic          data_16b_en;
  logic          cmos_vsyn;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic          wr_ack;
  logic [15:0]   wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          frame_done;
  logic          ovf;

  cam_burst_writer #(
    .BURST_LEN   (BURST),
    .FIFO_DEPTH  (DEPTH),
    .ADDR_W      (AW),
    .FRAME_WORDS (FRAME)
  ) dut (
    .cmos_pclk   (cmos_pclk),
    .rst         (rst),
    .data_16b    (data_16b),
    .data_16b_en (data_16b_en),
    .cmos_vsyn   (cmos_vsyn),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_ack      (wr_ack),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .frame_done  (frame_done),
    .ovf         (ovf)
  );

  always #5 cmos_pclk = ~cmos_pclk;

  typedef struct {
    int            ack_delay;
    int            ready_mode;
    logic [AW-1:0] exp_addr;
    logic [AW-1:0] exp_next;
    int            exp_fd;
  } row_t;

  row_t rows [8];

  int            checks = 0;
  int            failures = 0;
  int            cyc, feed_left, ack_delay, ready_mode, req_age, model_cnt;
  int            beats, data_err, addr_err, req_err, fd_cnt;
  logic [15:0]   feed_val, bad_got, bad_exp;
  logic          prev_ack, req_seen;
  logic [AW-1:0] burst_addr;
  logic [15:0]   exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_bench();
    cyc = 0; feed_left = 0; feed_val = 0; req_age = 0; model_cnt = 0;
    ack_delay = HOLD; ready_mode = 0;
    beats = 0; data_err = 0; addr_err = 0; req_err = 0; fd_cnt = 0;
    prev_ack = 1'b0; req_seen = 1'b0; burst_addr = '0;
    bad_got = '0; bad_exp = '0;
    exp_q.delete();
  endtask

  task automatic do_reset(input bit chk);
    rst = 1'b1;
    data_16b = '0; data_16b_en = 1'b0; cmos_vsyn = 1'b0; wr_ack = 1'b0; wr_ready = 1'b0;
    repeat (2) @(negedge cmos_pclk);
    if (chk) begin
      check("reset wr_req", wr_req, 0);
      check("reset wr_valid", wr_valid, 0);
      check("reset wr_addr", wr_addr, 0);
      check("reset wr_data", wr_data, 0);
      check("reset frame_done", frame_done, 0);
      check("reset ovf", ovf, 0);
    end
    rst = 1'b0;
    clear_bench();
  endtask

  // One clock: sample outputs, then drive the next inputs, all at the falling edge.
  task automatic cycle();
    logic        rd;
    logic [15:0] e;
    @(negedge cmos_pclk);
    cyc++;
    if (frame_done) fd_cnt++;
    if (prev_ack && wr_req) req_err++;
    if (wr_req && req_age == 0) burst_addr = wr_addr;
    if (wr_req) req_seen = 1'b1;
    req_age  = wr_req ? req_age + 1 : 0;
    wr_ack   = wr_req && (req_age > ack_delay);
    prev_ack = wr_ack;
    case (ready_mode)
      0:       wr_ready = 1'b1;
      1:       wr_ready = (cyc % 2 == 0);
      default: wr_ready = (cyc % 3 != 0);
    endcase
    rd = wr_valid && wr_ready;
    if (rd) begin
      if (exp_q.size() == 0) begin
        data_err++;
      end else begin
        e = exp_q.pop_front();
        if (wr_data !== e) begin
          if (data_err == 0) begin bad_got = wr_data; bad_exp = e; end
          data_err++;
        end
      end
      if (wr_addr !== burst_addr) addr_err++;
      beats++;
      model_cnt--;
    end
    if (feed_left > 0) begin
      data_16b_en = 1'b1;
      data_16b    = feed_val;
      if (model_cnt < DEPTH || rd) begin
        exp_q.push_back(feed_val);
        model_cnt++;
      end
      feed_val++;
      feed_left--;
    end else begin
      data_16b_en = 1'b0;
    end
  endtask

  task automatic run_beats(input int target, input int budget, input string name);
    for (int c = 0; c < budget && beats < target; c++) cycle();
    check(name, beats, target);
  endtask

  task automatic check_data(input string name);
    if (data_err != 0) $display("FAIL %s first bad beat: got %0d expected %0d", name, bad_got, bad_exp);
    check(name, data_err, 0);
  endtask

  initial begin
    rows[0] = '{3, 0, 0,    256,  0};
    rows[1] = '{0, 1, 256,  512,  0};
    rows[2] = '{1, 2, 512,  768,  0};
    rows[3] = '{3, 1, 768,  1024, 0};
    rows[4] = '{2, 0, 1024, 1280, 0};
    rows[5] = '{0, 2, 1280, 1536, 0};
    rows[6] = '{5, 1, 1536, 1792, 0};
    rows[7] = '{3, 0, 1792, 0,    1};

    // Reset values, then the request threshold: 255 words never request, the 256th does two cycles later.
    do_reset(1'b1);
    feed_left = 255;
    repeat (258) cycle();
    check("no request below burst", req_seen, 0);
    feed_left = 1;
    cycle();
    cycle();
    check("wr_req one cycle after 256th word", wr_req, 0);
    cycle();
    check("wr_req two cycles after 256th word", wr_req, 1);
    check("threshold wr_addr", wr_addr, 0);

    // One frame of bursts with varied ack latency and sink back-pressure.
    do_reset(1'b0);
    for (int r = 0; r < 8; r++) begin
      ack_delay  = rows[r].ack_delay;
      ready_mode = rows[r].ready_mode;
      feed_left  = BURST;
      beats = 0; data_err = 0; addr_err = 0; req_err = 0; fd_cnt = 0;
      run_beats(BURST, 3000, $sformatf("row%0d beats", r));
      cycle();
      cycle();
      check($sformatf("row%0d burst addr", r), burst_addr, rows[r].exp_addr);
      check_data($sformatf("row%0d data", r));
      check($sformatf("row%0d addr stable", r), addr_err, 0);
      check($sformatf("row%0d req drop after ack", r), req_err, 0);
      check($sformatf("row%0d frame_done pulses", r), fd_cnt, rows[r].exp_fd);
      check($sformatf("row%0d next addr", r), wr_addr, rows[r].exp_next);
      check($sformatf("row%0d ovf", r), ovf, 0);
    end

    // Overflow: hold the ack while 600 words arrive; only the first 512 survive.
    do_reset(1'b0);
    feed_left = DEPTH;
    repeat (DEPTH + 2) cycle();
    check("ovf clear at exactly full", ovf, 0);
    check("request pending while full", wr_req, 1);
    feed_left = 600 - DEPTH;
    repeat (600 - DEPTH + 2) cycle();
    check("ovf set after drop", ovf, 1);
    ack_delay = 2;
    run_beats(2 * BURST, 3000, "ovf drain beats");
    repeat (5) cycle();
    check_data("ovf drain data");
    check("ovf drain addr after two bursts", wr_addr, 2 * BURST);
    check("no third burst", wr_req, 0);
    check("ovf sticky", ovf, 1);

    // Frame start mid-burst with 100 residual words: burst finishes, then flush and address reset.
    do_reset(1'b0);
    feed_left = BURST + 100;
    repeat (BURST + 104) cycle();
    ack_delay = 0;
    run_beats(50, 1000, "sof pre-edge beats");
    cmos_vsyn = 1'b1;
    run_beats(BURST, 1000, "sof burst completes");
    cmos_vsyn = 1'b0;
    repeat (3) cycle();
    check_data("sof burst data");
    check("sof wr_addr reset", wr_addr, 0);
    exp_q.delete();
    model_cnt = 0;
    feed_val  = 16'd1000;
    feed_left = BURST - 1;
    req_seen  = 1'b0;
    repeat (BURST + 4) cycle();
    check("no request from residual words", req_seen, 0);
    feed_left = 1;
    beats = 0; data_err = 0;
    run_beats(BURST, 1000, "post-flush beats");
    check("post-flush burst addr", burst_addr, 0);
    check_data("post-flush data");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cam_burst_writer.md
Name: cam_burst_writer

Overview:
- Consumes the 16-bit pixel stream from the camera receiver (data_16b / data_16b_en) in the cmos_pclk domain.
- Buffers the pixels in an internal FIFO.
- Once a full burst of BURST_LEN words is buffered, issues an address-qualified burst write request to the frame-buffer write port (SDRAM write controller side).
- Tracks the frame write address, resets it at frame start (cmos_vsyn rising edge), and flags frame completion and overflow.

Parameters:
- BURST_LEN, 256: words per write burst. Power of 2.
- FIFO_DEPTH, 512: internal buffer depth in words. Power of 2, must be >= 2*BURST_LEN.
- ADDR_W, 22: width of the word address.
- FRAME_WORDS, 307200: words per frame (640x480). Must be a multiple of BURST_LEN.

Ports:
- cmos_pclk, in, 1: sole clock. All logic runs on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- data_16b, in, 16: pixel word from the receiver.
- data_16b_en, in, 1: one-cycle qualifier for data_16b.
- cmos_vsyn, in, 1: camera vsync, already in the cmos_pclk domain. A rising edge marks frame start.
- wr_req, out, 1: burst request. Held high until acknowledged.
- wr_addr, out, ADDR_W: burst start word address. Stable from wr_req assertion until the last beat.
- wr_ack, in, 1: request accepted.
- wr_data, out, 16: burst beat data (FIFO head, first-word-fall-through).
- wr_valid, out, 1: beat valid.
- wr_ready, in, 1: sink accepts the beat.
- frame_done, out, 1: one-cycle pulse after the last beat of a frame.
- ovf, out, 1: sticky overflow flag. Cleared only by rst.

Behaviour:
- Reset values: wr_req=0, wr_valid=0, wr_addr=0, wr_data=0, frame_done=0, ovf=0. FIFO empty, state IDLE, sof_pend=0, vsync history register=0.
- Reset is legal mid-burst: it aborts immediately, and the sink must tolerate a truncated burst.
- FIFO write:
  - A word is written on any cycle with data_16b_en=1, provided count<FIFO_DEPTH or a read occurs in the same cycle.
  - A write into a full FIFO with no simultaneous read drops the word and sets ovf.
  - A written word becomes visible in count on the next cycle.
  - Simultaneous read and write leaves count unchanged.
- FIFO read: a read occurs when wr_valid && wr_ready. wr_data always shows the head entry, with no read latency.
- Frame start:
  - sof = cmos_vsyn && !vsyn_d1, using one register of history.
  - In IDLE: on the next cycle, the FIFO is flushed (count=0), wr_addr=0 and the beat counter is cleared. A data_16b_en in the same cycle as the flush is discarded.
  - In REQ or DATA: sof_pend is set. The current burst completes normally, then the flush and address reset are applied on entry to IDLE.
- State machine:
  - IDLE -> REQ when count >= BURST_LEN and sof_pend=0. wr_req rises on the cycle the state enters REQ.
  - REQ -> DATA on the cycle after wr_ack=1 is sampled. wr_req deasserts in that same cycle. wr_ack is ignored outside REQ.
  - DATA: wr_valid=1 whenever count>0. Beat counter increments per accepted beat. Stalls through wr_ready=0 and through an empty FIFO (wr_valid=0).
  - DATA -> IDLE after the BURST_LEN-th accepted beat. wr_addr then advances by BURST_LEN, or wraps to 0 if wr_addr+BURST_LEN == FRAME_WORDS.
  - On wrap, frame_done pulses for one cycle on the first IDLE cycle.
- Arithmetic: wr_addr is ADDR_W bits unsigned. Beat counter is log2(BURST_LEN)+1 bits. FIFO pointers are log2(FIFO_DEPTH) bits with natural wrap. Count is log2(FIFO_DEPTH)+1 bits.
- Partial bursts are never issued. Residual words at frame start are discarded by the flush.

Decomposition:
- Shared package cam_pkg holds:
  - State encoding: IDLE, REQ, DATA.
  - Default constants: CAM_H=640, CAM_V=480, CAM_FRAME_WORDS, CAM_BURST_LEN.
- One natural sub-module: cam_sync_fifo. It is a single-clock, FWFT, 16-bit register-array FIFO with count, full, empty and flush ports.

Test Plan:
- Stream 256 words with values 0..255, 1 per cycle, wr_ack after 3 cycles, wr_ready=1 -> one burst at wr_addr=0, wr_data 0..255 in order, next wr_addr=256, ovf=0.
- Stream 255 words -> wr_req stays 0. The 256th word -> wr_req rises 2 cycles after that word's data_16b_en.
- wr_ready toggled 1/0 every cycle during a burst -> exactly 256 beats, no duplicated or skipped values, wr_addr stable throughout.
- Hold wr_ack=0 while streaming 600 words -> words 513..600 dropped, ovf=1 and sticky. After the ack, bursts carry words 0..511.
- Stream 1200 full bursts (FRAME_WORDS) -> frame_done pulses exactly once after beat 307200, and the next wr_addr=0.
- cmos_vsyn rising edge mid-burst with 100 residual words buffered -> the burst completes, then the FIFO is flushed, wr_addr=0, and no request is made until 256 new words arrive.
